// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming non-overlapping POOLxPOOL sum/max pooling of raster-order frames.
// Optional feature: define POOL_ROUND_EN to turn avg-mode window sums into rounded means.
module pool2d_stream #(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IN_WIDTH   = 4,
  parameter int unsigned POOL       = 2,
  parameter int unsigned OUT_WIDTH  = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic [CHANNELS*IN_WIDTH-1:0]  din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last
);

  localparam int unsigned Lg     = $clog2(POOL);
  localparam int unsigned AccW   = IN_WIDTH + 2 * Lg;
  localparam int unsigned NumWin = IMG_WIDTH / POOL;
  localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned IdxW   = (NumWin > 1) ? $clog2(NumWin) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_HEIGHT - 1);

`ifdef POOL_ROUND_EN
  localparam int unsigned MinOutW = IN_WIDTH;
  localparam logic [AccW:0] RoundBias = (AccW + 1)'(1) << (2 * Lg - 1);
`else
  localparam int unsigned MinOutW = AccW;
`endif

  if (OUT_WIDTH < MinOutW || POOL < 2 || POOL > 8 || (POOL & (POOL - 1)) != 0 ||
      (IMG_WIDTH % POOL) != 0 || (IMG_HEIGHT % POOL) != 0) begin : gen_param_check
    $error("pool2d_stream: illegal parameter combination");
  end

  logic [ColW-1:0]              col_q;
  logic [RowW-1:0]              row_q;
  logic                         mode_q;
  logic [AccW-1:0]              h_acc_q [CHANNELS];
  logic [AccW-1:0]              band_q  [NumWin][CHANNELS];
  logic [CHANNELS*OUT_WIDTH-1:0] dout_q;
  logic                         dout_valid_q;
  logic                         dout_last_q;

  logic                         cur_mode;
  logic                         in_fire, out_fire, load;
  logic                         col_first, col_last, row_first, row_last;
  logic                         frame_start, frame_end;
  logic [IdxW-1:0]              win_idx;
  logic [AccW-1:0]              px;
  logic [AccW-1:0]              h_new   [CHANNELS];
  logic [AccW-1:0]              v_new   [CHANNELS];
  logic [CHANNELS*OUT_WIDTH-1:0] dout_d;
`ifdef POOL_ROUND_EN
  logic [AccW:0]                rounded;
`endif

  function automatic logic [AccW-1:0] merge(input logic m, input logic [AccW-1:0] a,
                                            input logic [AccW-1:0] b);
    if (m) return (a > b) ? a : b;
    return a + b;
  endfunction

  assign din_ready  = !dout_valid_q || dout_ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

  always_comb begin
    in_fire     = din_valid && din_ready;
    out_fire    = dout_valid_q && dout_ready;
    col_first   = ~|col_q[Lg-1:0];
    col_last    = &col_q[Lg-1:0];
    row_first   = ~|row_q[Lg-1:0];
    row_last    = &row_q[Lg-1:0];
    frame_start = (col_q == '0) && (row_q == '0);
    frame_end   = (col_q == ColMax) && (row_q == RowMax);
    load        = in_fire && col_last && row_last;
    win_idx     = IdxW'(col_q >> Lg);
    // The (0,0) pixel already belongs to the new frame, so it uses the incoming mode.
    cur_mode    = frame_start ? mode : mode_q;
    px          = '0;
    dout_d      = '0;
`ifdef POOL_ROUND_EN
    rounded     = '0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      px       = AccW'(din[c*IN_WIDTH +: IN_WIDTH]);
      h_new[c] = col_first ? px : merge(cur_mode, h_acc_q[c], px);
      v_new[c] = row_first ? h_new[c] : merge(cur_mode, band_q[win_idx][c], h_new[c]);
`ifdef POOL_ROUND_EN
      rounded  = ({1'b0, v_new[c]} + RoundBias) >> (2 * Lg);
      dout_d[c*OUT_WIDTH +: OUT_WIDTH] = cur_mode ? OUT_WIDTH'(v_new[c]) : OUT_WIDTH'(rounded);
`else
      dout_d[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(v_new[c]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) h_acc_q[c] <= '0;
    end else begin
      if (in_fire) begin
        if (frame_start) mode_q <= mode;
        if (col_q == ColMax) begin
          col_q <= '0;
          row_q <= (row_q == RowMax) ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
        for (int c = 0; c < CHANNELS; c++) h_acc_q[c] <= h_new[c];
      end
      if (load) begin
        dout_q       <= dout_d;
        dout_valid_q <= 1'b1;
        dout_last_q  <= frame_end;
      end else if (out_fire) begin
        dout_valid_q <= 1'b0;
        dout_last_q  <= 1'b0;
      end
    end
  end

  // Band rows other than the last fold their horizontal result into the column buffer.
  always_ff @(posedge clk) begin
    if (in_fire && col_last && !row_last) begin
      for (int c = 0; c < CHANNELS; c++) band_q[win_idx][c] <= v_new[c];
    end
  end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Streaming 2-D pooling engine for raster-order feature maps with non-overlapping POOL×POOL windows (stride = POOL). It supports CHANNELS parallel lanes and a run-time choice of average (sum) or max pooling. It accepts one pixel per handshake and emits one pooled pixel per completed window on a registered ready/valid output with true backpressure. It sits between convolution/activation stages and the next layer, and replaces the fixed 2×2 sum-pool stage.

## Interface
- IMG_WIDTH, 32: pixels per row; multiple of POOL.
- IMG_HEIGHT, 32: rows per frame; multiple of POOL.
- CHANNELS, 1: parallel lanes; lane c occupies bits [c*IN_WIDTH +: IN_WIDTH].
- IN_WIDTH, 4: unsigned bits per lane, input.
- POOL, 2: window edge and stride; power of two, 2..8.
- OUT_WIDTH, 6: unsigned bits per lane, output.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mode  in  1  0 = average/sum, 1 = max; sampled only on the first pixel of a frame.
- din  in  CHANNELS*IN_WIDTH  input pixel, all lanes.
- din_valid  in  1  input valid.
- din_ready  out  1  = !dout_valid || dout_ready (combinational).
- dout  out  CHANNELS*OUT_WIDTH  pooled pixel, all lanes.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.
- dout_last  out  1  high with the final pooled pixel of a frame.

## Operation
- Input handshake: din_valid && din_ready. Output handshake: dout_valid && dout_ready.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on each input handshake.
  - col wraps to 0 and row increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0, which starts a new frame.
- Frame mode register is loaded from mode on the handshake at (0,0). mode changes at any other time are ignored.
- Per lane, a horizontal accumulator h_acc combines POOL consecutive pixels of a row.
  - avg mode: sum.
  - max mode: maximum.
  - Loaded (not combined) when col%POOL == 0.
- Band buffer: IMG_WIDTH/POOL entries × CHANNELS × ACC_W, where ACC_W = IN_WIDTH + 2*log2(POOL). Indexed by col/POOL.
  - At each window column end (col%POOL == POOL-1):
    - row%POOL == 0: buffer entry ← h_acc combined with din.
    - Middle rows: entry ← entry ⊕ (h_acc ⊕ din).
    - row%POOL == POOL-1: the final result is computed and loaded into the output register; the entry is not written.
  - ⊕ is + in avg mode and max in max mode.
  - The buffer is not reset; the first band row always overwrites it.
- Result per lane, avg mode without POOL_ROUND_EN: the raw sum, zero-extended to OUT_WIDTH.
- Result per lane, max mode: the max, zero-extended to OUT_WIDTH.
- Width rule: OUT_WIDTH ≥ ACC_W. Elaboration fails otherwise; arithmetic never wraps.
- dout_last is set with the result when row == IMG_HEIGHT-1 and col == IMG_WIDTH-1.
- Output register holds dout, dout_valid and dout_last stable until the output handshake.
  - On the output handshake, dout_valid clears unless a new result loads in the same cycle. In that case dout_valid stays 1 with the new data.

## Timing
- Reset values: dout = 0, dout_valid = 0, dout_last = 0. Internal state: col = 0, row = 0, h_acc = 0, frame mode = 0.
- Latency: dout_valid rises the cycle after the handshake of the window's bottom-right pixel.
- Throughput: one input pixel per cycle while dout_ready = 1; at most one output per POOL inputs.
- Backpressure:
  - While dout_valid && !dout_ready, din_ready = 0.
  - No input is consumed.
  - All counters and accumulators hold.
- Simultaneous output handshake and new-result load: the new result wins and no bubble is inserted.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronous).
  - Any partial window is discarded.
  - The next accepted pixel is treated as (0,0) of a new frame.
- din_valid low mid-row: state holds indefinitely; no timeout.

## Configuration
- POOL_ROUND_EN defined: avg-mode result = (sum + 2^(2·log2(POOL)−1)) >> 2·log2(POOL), a rounded mean. Required OUT_WIDTH relaxes to ≥ IN_WIDTH. Max mode is unaffected.
- POOL_ROUND_EN undefined: avg mode outputs the raw sum, and OUT_WIDTH ≥ ACC_W is required.

## Test plan
- Avg mode, 4×4, POOL=2, CHANNELS=1, IN_WIDTH=4, pixel = 4·row+col, dout_ready=1 → dout 10, 18, 42, 50. dout_last only on 50. Each output appears 1 cycle after pixels 5, 7, 13, 15.
- Max mode, same stimulus → dout 5, 7, 13, 15.
- CHANNELS=2, lane0 = 4·row+col, lane1 = 15−lane0, avg → lane pairs (10,50), (18,42), (42,18), (50,10).
- Backpressure: dout_ready=0 for 5 cycles once the first result is valid → dout stays 10 and din_ready = 0 throughout. Release → 18, 42, 50 follow with no loss or duplication.
- mode toggled to 1 after pixel 3 of an avg frame → the frame still yields 10, 18, 42, 50. The next frame, with mode=1 at (0,0), yields 5, 7, 13, 15.
- rst_n pulsed after pixel 6, then a full frame sent → exactly 10, 18, 42, 50. With POOL_ROUND_EN defined → 3, 5, 11, 13.
